// File: rtl/session_pkg.sv
// Shared session-layer definitions: call-state encoding, control opcodes and
// the transport-to-session strobe codes used by both transport directions.
package session_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCalling   = 3'd1,
    StRinging   = 3'd2,
    StConnected = 3'd3
  } call_state_e;

  typedef enum logic [1:0] {
    SendIdle  = 2'b00,
    SendCtrl  = 2'b01,
    SendAudio = 2'b10,
    SendRsvd  = 2'b11
  } send_code_e;

  localparam logic [3:0] OpCallReq   = 4'd1;
  localparam logic [3:0] OpAccept    = 4'd2;
  localparam logic [3:0] OpHangup    = 4'd3;
  localparam logic [3:0] OpKeepalive = 4'd4;

  function automatic logic [3:0] ctrl_opcode(input logic [15:0] word);
    return word[15:12];
  endfunction

  function automatic logic [7:0] ctrl_arg(input logic [15:0] word);
    return word[7:0];
  endfunction

endpackage

// File: rtl/session_rcv_if.sv
// Transport-receive to session handshake: strobed word plus backpressure.
interface session_rcv_if;
  logic [1:0]  sendingToSession;
  logic [15:0] data;
  logic        sessionBusy;

  modport master (
    output sendingToSession,
    output data,
    input  sessionBusy
  );

  modport slave (
    input  sendingToSession,
    input  data,
    output sessionBusy
  );
endinterface

// File: rtl/session_audio_fifo.sv
// Synchronous audio FIFO with occupancy count and a flush that overrides
// reads and writes. A write on a full FIFO succeeds when a read happens too.
module session_audio_fifo #(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     wr_i,
  input  logic [15:0]              wr_data_i,
  input  logic                     rd_i,
  output logic [15:0]              rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW   = $clog2(Depth);
  localparam int unsigned CntW = AW + 1;

  logic [15:0]     mem_q [Depth];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            rd_en, wr_en;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CntW'(Depth));
  assign count_o   = cnt_q;
  assign rd_data_o = empty_o ? 16'h0000 : mem_q[rptr_q];

  always_comb begin
    rd_en  = rd_i && !empty_o;
    wr_en  = wr_i && (!full_o || rd_en);
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + AW'(1);
      if (rd_en) rptr_d = rptr_q + AW'(1);
      cnt_d = cnt_q + CntW'(wr_en) - CntW'(rd_en);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (wr_en && !flush_i) mem_q[wptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/session_rcv.sv
// Session receive: registered word decode, call-state FSM and audio buffering.
// Define SESSION_RCV_TIMEOUT_EN to drop CONNECTED calls after link silence.
module session_rcv
  import session_pkg::*;
#(
  parameter int unsigned AUDIO_DEPTH    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  session_rcv_if.slave        rx,
  input  logic                localDial,
  input  logic                localAccept,
  input  logic [7:0]          localPeer,
  input  logic                audioRd,
  output logic [15:0]         audioOut,
  output logic                audioEmpty,
  output logic [2:0]          callState,
  output logic [7:0]          peerAddr,
  output logic                ring,
  output logic                hangupPulse,
  output logic [7:0]          dropCount
);

  localparam int unsigned CntW = $clog2(AUDIO_DEPTH) + 1;

  if (AUDIO_DEPTH < 4 || AUDIO_DEPTH > 256 || (AUDIO_DEPTH & (AUDIO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("AUDIO_DEPTH must be a power of two in 4..256");
  end
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be non-zero");
  end

  logic        ctrl_vld_q, ctrl_vld_d;
  logic        aud_vld_q, aud_vld_d;
  logic [15:0] word_q, word_d;

  call_state_e state_q, state_d;
  logic [7:0]  peer_q, peer_d;
  logic        hangup_q, hangup_d;
  logic [7:0]  drop_q, drop_d;

  logic [3:0]      opcode;
  logic [7:0]      arg;
  logic            is_call_req, is_accept, is_hangup;
  logic            exit_idle, timeout;
  logic            fifo_wr, fifo_full, drop;
  logic [CntW-1:0] fifo_cnt;

  // Decode stage: every strobed word is held one cycle before it acts.
  always_comb begin
    ctrl_vld_d = (rx.sendingToSession == SendCtrl);
    aud_vld_d  = (rx.sendingToSession == SendAudio);
    word_d     = (ctrl_vld_d || aud_vld_d) ? rx.data : word_q;
  end

  assign opcode      = ctrl_opcode(word_q);
  assign arg         = ctrl_arg(word_q);
  assign is_call_req = ctrl_vld_q && (opcode == OpCallReq);
  assign is_accept   = ctrl_vld_q && (opcode == OpAccept);
  assign is_hangup   = ctrl_vld_q && (opcode == OpHangup);

`ifdef SESSION_RCV_TIMEOUT_EN
  logic [31:0] timer_q, timer_d;
  logic        is_keepalive;

  assign is_keepalive = ctrl_vld_q && (opcode == OpKeepalive);

  always_comb begin
    timer_d = '0;
    timeout = 1'b0;
    if (state_q == StConnected) begin
      timer_d = (aud_vld_q || is_keepalive) ? 32'd0 : timer_q + 32'd1;
      timeout = (timer_d == TIMEOUT_CYCLES);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= timer_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    peer_d  = peer_q;
    case (state_q)
      StIdle: begin
        if (is_call_req) begin
          state_d = StRinging;
          peer_d  = arg;
        end else if (localDial) begin
          state_d = StCalling;
          peer_d  = localPeer;
        end
      end
      StCalling: begin
        if (is_accept && arg == peer_q) state_d = StConnected;
      end
      StRinging: begin
        if (localAccept) state_d = StConnected;
      end
      StConnected: ;
      default: state_d = StIdle;
    endcase
    // Teardown overrides any other transition out of a live call.
    if (state_q != StIdle && ((is_hangup && arg == peer_q) || timeout)) state_d = StIdle;
    exit_idle = (state_q != StIdle) && (state_d == StIdle);
    hangup_d  = exit_idle;
  end

  // A full FIFO only loses the word when no pop frees a slot this cycle.
  always_comb begin
    fifo_wr = aud_vld_q && (state_q == StConnected);
    drop    = fifo_wr && fifo_full && !audioRd && !exit_idle;
    drop_d  = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_vld_q <= 1'b0;
      aud_vld_q  <= 1'b0;
      word_q     <= '0;
      state_q    <= StIdle;
      peer_q     <= '0;
      hangup_q   <= 1'b0;
      drop_q     <= '0;
    end else begin
      ctrl_vld_q <= ctrl_vld_d;
      aud_vld_q  <= aud_vld_d;
      word_q     <= word_d;
      state_q    <= state_d;
      peer_q     <= peer_d;
      hangup_q   <= hangup_d;
      drop_q     <= drop_d;
    end
  end

  session_audio_fifo #(
    .Depth (AUDIO_DEPTH)
  ) u_fifo (
    .clk_i     (clk),
    .rst_ni    (reset),
    .flush_i   (exit_idle),
    .wr_i      (fifo_wr),
    .wr_data_i (word_q),
    .rd_i      (audioRd),
    .rd_data_o (audioOut),
    .empty_o   (audioEmpty),
    .full_o    (fifo_full),
    .count_o   (fifo_cnt)
  );

  // Two slots of headroom absorb the upstream reaction delay.
  assign rx.sessionBusy = (fifo_cnt >= CntW'(AUDIO_DEPTH - 2)) || ctrl_vld_q;

  assign callState   = state_q;
  assign peerAddr    = peer_q;
  assign ring        = (state_q == StRinging);
  assign hangupPulse = hangup_q;
  assign dropCount   = drop_q;

endmodule

// File: tb/tb_session_rcv.sv
// Directed bench for session_rcv: call setup/teardown, audio buffering, drops,
// backpressure, reset and (when SESSION_RCV_TIMEOUT_EN is defined) timeout.
module tb_session_rcv;

  logic        clk;
  logic        reset;
  logic        localDial, localAccept, audioRd;
  logic [7:0]  localPeer;
  logic [15:0] audioOut;
  logic        audioEmpty, ring, hangupPulse;
  logic [2:0]  callState;
  logic [7:0]  peerAddr, dropCount;

  int n_pass  = 0;
  int n_total = 0;

  session_rcv_if bus ();

  session_rcv #(
    .AUDIO_DEPTH    (16),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (bus),
    .localDial   (localDial),
    .localAccept (localAccept),
    .localPeer   (localPeer),
    .audioRd     (audioRd),
    .audioOut    (audioOut),
    .audioEmpty  (audioEmpty),
    .callState   (callState),
    .peerAddr    (peerAddr),
    .ring        (ring),
    .hangupPulse (hangupPulse),
    .dropCount   (dropCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] code, input logic [15:0] w);
    bus.sendingToSession = code;
    bus.data             = w;
    step();
    bus.sendingToSession = 2'b00;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_state"}, 32'(callState), 0);
    chk({pfx, "_peer"}, 32'(peerAddr), 0);
    chk({pfx, "_ring"}, 32'(ring), 0);
    chk({pfx, "_hangup"}, 32'(hangupPulse), 0);
    chk({pfx, "_busy"}, 32'(bus.sessionBusy), 0);
    chk({pfx, "_empty"}, 32'(audioEmpty), 1);
    chk({pfx, "_audio"}, 32'(audioOut), 0);
    chk({pfx, "_drop"}, 32'(dropCount), 0);
  endtask

  initial begin
    int cnt;
    logic [15:0] exp_w;
    reset                = 1'b0;
    bus.sendingToSession = 2'b00;
    bus.data             = 16'h0000;
    localDial            = 1'b0;
    localAccept          = 1'b0;
    localPeer            = 8'h00;
    audioRd              = 1'b0;

    #3;
    chk_reset_vals("por");
    #9;
    reset = 1'b1;
    step();
    chk("idle_after_por", 32'(callState), 0);

    // Audio outside CONNECTED is discarded silently.
    send(2'b10, 16'h1234);
    step();
    chk("idle_audio_empty", 32'(audioEmpty), 1);
    chk("idle_audio_nodrop", 32'(dropCount), 0);

    // Incoming call, then local accept.
    send(2'b01, 16'h1005);
    chk("ctrl_pending_busy", 32'(bus.sessionBusy), 1);
    chk("ctrl_latency_state", 32'(callState), 0);
    step();
    chk("ringing_state", 32'(callState), 2);
    chk("ringing_ring", 32'(ring), 1);
    chk("ringing_peer", 32'(peerAddr), 32'h05);
    chk("ringing_busy_clear", 32'(bus.sessionBusy), 0);
    localAccept = 1'b1;
    step();
    localAccept = 1'b0;
    chk("accept_state", 32'(callState), 3);
    chk("accept_ring", 32'(ring), 0);

    // Three queued words, one pop, then hangup.
    send(2'b10, 16'hA001);
    send(2'b10, 16'hA002);
    send(2'b10, 16'hA003);
    step();
    chk("q3_empty", 32'(audioEmpty), 0);
    chk("q3_head", 32'(audioOut), 32'hA001);
    audioRd = 1'b1;
    step();
    audioRd = 1'b0;
    chk("q3_pop_head", 32'(audioOut), 32'hA002);
    send(2'b01, 16'h3006);
    step();
    chk("hangup_mismatch", 32'(callState), 3);
    send(2'b01, 16'h3005);
    step();
    chk("hangup_state", 32'(callState), 0);
    chk("hangup_pulse", 32'(hangupPulse), 1);
    chk("hangup_flush", 32'(audioEmpty), 1);
    chk("hangup_drop", 32'(dropCount), 0);
    step();
    chk("hangup_pulse_end", 32'(hangupPulse), 0);

    // Outgoing call: wrong accept argument ignored, matching one connects.
    localPeer = 8'h22;
    localDial = 1'b1;
    step();
    localDial = 1'b0;
    chk("dial_state", 32'(callState), 1);
    chk("dial_peer", 32'(peerAddr), 32'h22);
    send(2'b10, 16'hBEEF);
    step();
    chk("calling_audio_empty", 32'(audioEmpty), 1);
    send(2'b01, 16'h2023);
    step();
    chk("accept_mismatch", 32'(callState), 1);
    send(2'b01, 16'h2022);
    step();
    chk("accept_match", 32'(callState), 3);

    // 18 words into a 16-deep FIFO; busy from occupancy 14.
    for (int s = 1; s <= 18; s++) begin
      bus.sendingToSession = 2'b10;
      bus.data             = 16'hC000 + 16'(s - 1);
      step();
      chk($sformatf("fill_busy_%0d", s), 32'(bus.sessionBusy), ((s - 1) >= 14) ? 1 : 0);
    end
    bus.sendingToSession = 2'b00;
    step();
    chk("full_drop", 32'(dropCount), 2);
    chk("full_busy", 32'(bus.sessionBusy), 1);
    chk("full_head", 32'(audioOut), 32'hC000);

    // Write and read together on a full FIFO: no drop.
    send(2'b10, 16'hC0FF);
    audioRd = 1'b1;
    step();
    audioRd = 1'b0;
    chk("full_rw_drop", 32'(dropCount), 2);
    chk("full_rw_head", 32'(audioOut), 32'hC001);
    chk("full_rw_busy", 32'(bus.sessionBusy), 1);
    for (int i = 0; i < 16; i++) begin
      exp_w = (i < 15) ? 16'hC001 + 16'(i) : 16'hC0FF;
      chk($sformatf("drain_%0d", i), 32'(audioOut), 32'(exp_w));
      audioRd = 1'b1;
      step();
      audioRd = 1'b0;
    end
    chk("drained_empty", 32'(audioEmpty), 1);
    chk("drained_audio", 32'(audioOut), 0);
    audioRd = 1'b1;
    step();
    audioRd = 1'b0;
    chk("underflow_empty", 32'(audioEmpty), 1);
    chk("underflow_busy", 32'(bus.sessionBusy), 0);
    send(2'b10, 16'hD00D);
    step();
    chk("after_underflow_head", 32'(audioOut), 32'hD00D);
    chk("after_underflow_empty", 32'(audioEmpty), 0);

    // Saturate the drop counter.
    for (int i = 0; i < 300; i++) begin
      bus.sendingToSession = 2'b10;
      bus.data             = 16'(i);
      step();
    end
    bus.sendingToSession = 2'b00;
    step();
    chk("drop_saturate", 32'(dropCount), 32'hFF);

    // Asynchronous reset in the middle of a call.
    reset = 1'b0;
    #2;
    chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;
    step();
    chk("rel_state", 32'(callState), 0);
    chk("rel_hangup", 32'(hangupPulse), 0);
    step();
    chk("rel_hangup2", 32'(hangupPulse), 0);

    // CALL_REQ beats a simultaneous localDial.
    localPeer = 8'h77;
    send(2'b01, 16'h1042);
    localDial = 1'b1;
    step();
    localDial = 1'b0;
    chk("callreq_wins_state", 32'(callState), 2);
    chk("callreq_wins_peer", 32'(peerAddr), 32'h42);

    // Reserved strobe code has no effect at all.
    send(2'b11, 16'h3042);
    chk("reserved_busy", 32'(bus.sessionBusy), 0);
    step();
    chk("reserved_state", 32'(callState), 2);
    localAccept = 1'b1;
    step();
    localAccept = 1'b0;
    chk("ring_accept2", 32'(callState), 3);

`ifdef SESSION_RCV_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      send(2'b01, 16'h4000);
      step();
      repeat (48) step();
      chk($sformatf("keepalive_hold_%0d", k), 32'(callState), 3);
    end
    send(2'b01, 16'h4000);
    step();
    cnt = 0;
    while (callState != 3'd0 && cnt < 200) begin
      step();
      cnt++;
    end
    chk("timeout_cycles", 32'(cnt), 100);
    chk("timeout_pulse", 32'(hangupPulse), 1);
`else
    cnt = 0;
    repeat (150) begin
      step();
      if (callState == 3'd3) cnt++;
    end
    chk("no_timeout_hold", 32'(cnt), 150);
    send(2'b01, 16'h3042);
    step();
    chk("final_hangup_state", 32'(callState), 0);
    chk("final_hangup_pulse", 32'(hangupPulse), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
